// File: rtl/dice_roller.sv
// Debounced roll button driving a 1..6 die face with coast-down and hold.
// Optional DICE_LFSR_EN: faces come from an 8-bit LFSR instead of counting.
module dice_roller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] ROLL_TICK_DIV   = 24'd2500000,
  parameter logic [3:0]  SETTLE_STEPS    = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll_btn,
  output logic [2:0] dice_value,
  output logic       rolling,
  output logic       valid
);

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SETTLE,
    SHOW
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  dice_nxt;
  logic [3:0]  settle_cnt;
  logic [3:0]  settle_nxt;

  logic        sync1;
  logic        sync2;
  logic        btn_db;
  logic        btn_q;
  logic [15:0] db_cnt;
  logic        db_hit;
  logic        press;
  logic        rel;

  logic [23:0] pcnt;
  logic        active;
  logic        tick;
  logic        enter_roll;
  logic [2:0]  adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= roll_btn;
      sync2 <= sync1;
    end
  end

  assign db_hit = ({1'b0, db_cnt} + 17'd1) >=
                  {1'b0, DEBOUNCE_CYCLES};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b0;
      btn_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      btn_q <= btn_db;
      if (sync2 != btn_db) begin
        if (db_hit) begin
          btn_db <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_q;
  assign rel   = ~btn_db & btn_q;

  assign active = (state == ROLL) || (state == SETTLE);
  assign tick   = active && (pcnt == ROLL_TICK_DIV - 24'd1);
  assign enter_roll = (state_nxt == ROLL) && (state != ROLL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (enter_roll) begin
      pcnt <= '0;
    end else if (active) begin
      pcnt <= tick ? 24'd0 : pcnt + 24'd1;
    end
  end

`ifdef DICE_LFSR_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_mod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign lfsr_mod = lfsr % 8'd6;
  assign adv      = lfsr_mod[2:0] + 3'd1;
`else
  assign adv = ((dice_value >= 3'd6) || (dice_value == 3'd0)) ?
               3'd1 : dice_value + 3'd1;
`endif

  always_comb begin
    state_nxt  = state;
    dice_nxt   = dice_value;
    settle_nxt = settle_cnt;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_nxt = ROLL;
          dice_nxt  = 3'd1;
        end
      end
      ROLL: begin
        if (tick) begin
          dice_nxt = adv;
        end
        if (rel) begin
          if (SETTLE_STEPS == 4'd0) begin
            state_nxt = SHOW;
          end else begin
            state_nxt  = SETTLE;
            settle_nxt = SETTLE_STEPS;
          end
        end
      end
      SETTLE: begin
        if (tick) begin
          dice_nxt = adv;
          if (settle_cnt <= 4'd1) begin
            state_nxt  = SHOW;
            settle_nxt = 4'd0;
          end else begin
            settle_nxt = settle_cnt - 4'd1;
          end
        end
      end
      SHOW: begin
        // Re-roll continues from the held face.
        if (press) begin
          state_nxt = ROLL;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dice_value <= 3'd0;
      settle_cnt <= 4'd0;
      rolling    <= 1'b0;
      valid      <= 1'b0;
    end else begin
      state      <= state_nxt;
      dice_value <= dice_nxt;
      settle_cnt <= settle_nxt;
      rolling    <= (state_nxt == ROLL) ||
                    (state_nxt == SETTLE);
      valid      <= (state_nxt == SHOW);
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller with small debounce/tick/settle values.
// With DICE_LFSR_EN defined it runs random-length rolls instead.
module tb_dice_roller;

  logic       clk;
  logic       rst_n;
  logic       roll_btn;
  logic [2:0] dice_value;
  logic       rolling;
  logic       valid;

  int n_chk;
  int n_fail;
  int e;

  dice_roller #(
    .DEBOUNCE_CYCLES(16'd4),
    .ROLL_TICK_DIV  (24'd3),
    .SETTLE_STEPS   (4'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .roll_btn  (roll_btn),
    .dice_value(dice_value),
    .rolling   (rolling),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  task automatic go(input int n);
    while (e < n) begin
      @(posedge clk);
      e++;
    end
    #2;
  endtask

  task automatic outs(input string tag,
                      input logic [2:0] d,
                      input logic r,
                      input logic v);
    chk({tag, ".dice"}, {5'd0, dice_value}, {5'd0, d});
    chk({tag, ".rolling"}, {7'd0, rolling}, {7'd0, r});
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
  endtask

`ifdef DICE_LFSR_EN
  logic [5:0] seen;

  task automatic cyc_check();
    @(posedge clk);
    #2;
    if (rolling || valid) begin
      chk("face_range",
          {7'd0, (dice_value >= 3'd1) && (dice_value <= 3'd6)},
          8'd1);
      if (dice_value >= 3'd1 && dice_value <= 3'd6)
        seen[dice_value - 3'd1] = 1'b1;
    end
  endtask
`endif

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    e        = 0;
    rst_n    = 1'b0;
    roll_btn = 1'b0;

    go(3);
    outs("reset", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    go(5);
    roll_btn = 1'b1;
    go(7);
    roll_btn = 1'b0;
    go(17);
    outs("glitch", 3'd0, 1'b0, 1'b0);

`ifdef DICE_LFSR_EN
    seen = '0;
    for (int r = 0; r < 1000; r++) begin
      roll_btn = 1'b1;
      repeat ($urandom_range(30, 7)) cyc_check();
      roll_btn = 1'b0;
      repeat (20) cyc_check();
    end
    chk("all_faces", {2'd0, seen}, 8'h3f);
`else
    e = 0;
    roll_btn = 1'b1;
    go(6);
    outs("pre_press", 3'd0, 1'b0, 1'b0);
    go(7);
    outs("roll_entry", 3'd1, 1'b1, 1'b0);
    go(9);
    outs("before_tick", 3'd1, 1'b1, 1'b0);
    go(10);
    outs("adv2", 3'd2, 1'b1, 1'b0);
    go(13);
    outs("adv3", 3'd3, 1'b1, 1'b0);
    go(16);
    outs("adv4", 3'd4, 1'b1, 1'b0);
    go(18);
    roll_btn = 1'b0;
    go(19);
    outs("adv5", 3'd5, 1'b1, 1'b0);
    go(22);
    outs("adv6", 3'd6, 1'b1, 1'b0);
    go(25);
    outs("wrap1_release", 3'd1, 1'b1, 1'b0);
    go(28);
    outs("settle_adv2", 3'd2, 1'b1, 1'b0);
    go(30);
    outs("pre_show", 3'd2, 1'b1, 1'b0);
    go(31);
    outs("show3", 3'd3, 1'b0, 1'b1);

    roll_btn = 1'b1;
    go(37);
    outs("reroll_pre", 3'd3, 1'b0, 1'b1);
    go(38);
    outs("reroll_entry", 3'd3, 1'b1, 1'b0);
    go(40);
    outs("reroll_hold", 3'd3, 1'b1, 1'b0);
    go(41);
    outs("reroll_adv4", 3'd4, 1'b1, 1'b0);
    roll_btn = 1'b0;
    go(44);
    outs("reroll_adv5", 3'd5, 1'b1, 1'b0);
    go(45);
    roll_btn = 1'b1;
    go(47);
    outs("reroll_adv6", 3'd6, 1'b1, 1'b0);
    go(48);
    outs("settle_entry", 3'd6, 1'b1, 1'b0);
    go(50);
    outs("settle_wrap", 3'd1, 1'b1, 1'b0);
    go(52);
    outs("press_in_settle", 3'd1, 1'b1, 1'b0);
    go(53);
    outs("show2", 3'd2, 1'b0, 1'b1);
    go(56);
    outs("show_hold", 3'd2, 1'b0, 1'b1);

    roll_btn = 1'b0;
    go(64);
    roll_btn = 1'b1;
    go(70);
    outs("roll3_pre", 3'd2, 1'b0, 1'b1);
    go(71);
    outs("roll3_entry", 3'd2, 1'b1, 1'b0);
    go(73);
    rst_n = 1'b0;
    #1;
    outs("async_reset", 3'd0, 1'b0, 1'b0);
    go(75);
    rst_n = 1'b1;
    go(81);
    outs("redebounce_pre", 3'd0, 1'b0, 1'b0);
    go(82);
    outs("redebounce_roll", 3'd1, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
